// File: rtl/serial_rx_buffer_if.sv
// Handshake/data bundle between a serial bit source, the rx buffer and its word consumer.
interface serial_rx_buffer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  i_en;
  logic                  i_din;
  logic                  i_din_valid;
  logic                  i_dout_ready;
  logic                  i_clr_overflow;
  logic [DATA_WIDTH-1:0] ov_dout;
  logic                  o_dout_valid;
  logic                  o_full;
  logic [CW-1:0]         ov_count;
  logic                  o_overflow;

  modport slave (
    input  i_en, i_din, i_din_valid, i_dout_ready, i_clr_overflow,
    output ov_dout, o_dout_valid, o_full, ov_count, o_overflow
  );

  modport master (
    output i_en, i_din, i_din_valid, i_dout_ready, i_clr_overflow,
    input  ov_dout, o_dout_valid, o_full, ov_count, o_overflow
  );
endinterface

// File: rtl/serial_rx_buffer.sv
// Assembles MSB-first serial bits into DATA_WIDTH words and queues them in a
// show-ahead FIFO with a sticky overflow flag for words dropped while full.
module serial_rx_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  serial_rx_buffer_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  accept, word_done, full, nonempty, pop, push, drop;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    accept    = bus.i_en & bus.i_din_valid;
    word_done = accept && (bitcnt_q == BW'(DATA_WIDTH-1));
    word      = {shift_q[DATA_WIDTH-2:0], bus.i_din};
    full      = (count_q == CW'(FIFO_DEPTH));
    nonempty  = (count_q != '0);
    pop       = nonempty & bus.i_dout_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    push      = word_done & (~full | pop);
    drop      = word_done & full & ~pop;

    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shift_d  = word;
      bitcnt_d = word_done ? '0 : bitcnt_q + BW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // Set wins over clear.
    ovf_d    = drop | (ovf_q & ~bus.i_clr_overflow);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset: entries are only visible once counted in.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign bus.ov_dout      = nonempty ? mem_q[rd_ptr_q] : '0;
  assign bus.o_dout_valid = nonempty;
  assign bus.o_full       = full;
  assign bus.ov_count     = count_q;
  assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_serial_rx_buffer.sv
// Directed bench for serial_rx_buffer: capture, gaps, fill/overflow, pop-on-full, reset.
module tb_serial_rx_buffer;
  localparam int DW = 24;
  localparam int FD = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  serial_rx_buffer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  serial_rx_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Sends one word MSB-first; optional gaps, and ready/clr asserted with the last bit.
  task automatic send_word(input logic [DW-1:0] w, input bit gap,
                           input bit rdy_last, input bit clr_last);
    logic [DW-1:0] v;
    v = w;
    for (int i = DW-1; i >= 0; i--) begin
      if (gap && (i % 2 == 1)) begin
        bus.i_din_valid = 1'b0; bus.i_din = ~v[i]; tick();
      end
      if (gap && i == 12) begin
        bus.i_en = 1'b0; bus.i_din_valid = 1'b1; bus.i_din = ~v[i];
        repeat (5) tick();
        bus.i_en = 1'b1;
      end
      if (i == 0) begin
        bus.i_dout_ready = rdy_last; bus.i_clr_overflow = clr_last;
        chk("no_early_push", 32'(bus.ov_count), gap ? 32'd0 : 32'(bus.ov_count));
      end
      bus.i_din = v[i]; bus.i_din_valid = 1'b1; bus.i_en = 1'b1;
      tick();
    end
    bus.i_din_valid = 1'b0; bus.i_dout_ready = 1'b0; bus.i_clr_overflow = 1'b0;
  endtask

  task automatic pop_one();
    bus.i_dout_ready = 1'b1; tick(); bus.i_dout_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout"},  32'(bus.ov_dout), 32'd0);
    chk({tag, "_valid"}, 32'(bus.o_dout_valid), 32'd0);
    chk({tag, "_full"},  32'(bus.o_full), 32'd0);
    chk({tag, "_count"}, 32'(bus.ov_count), 32'd0);
    chk({tag, "_ovf"},   32'(bus.o_overflow), 32'd0);
  endtask

  initial begin
    bus.i_en = 1'b0; bus.i_din = 1'b0; bus.i_din_valid = 1'b0;
    bus.i_dout_ready = 1'b0; bus.i_clr_overflow = 1'b0;
    repeat (2) tick();
    chk_reset_state("rst_hold");
    i_rst_n = 1'b1;
    tick();
    chk_reset_state("rst_after");

    // Single word, no pop
    send_word(24'hA5C3F0, 1'b0, 1'b0, 1'b0);
    chk("single_dout",  32'(bus.ov_dout), 32'hA5C3F0);
    chk("single_valid", 32'(bus.o_dout_valid), 32'd1);
    chk("single_count", 32'(bus.ov_count), 32'd1);
    pop_one();
    chk("single_pop_count", 32'(bus.ov_count), 32'd0);
    chk("single_pop_dout",  32'(bus.ov_dout), 32'd0);

    // Ready while empty does nothing
    bus.i_dout_ready = 1'b1; repeat (3) tick(); bus.i_dout_ready = 1'b0;
    chk("empty_ready_count", 32'(bus.ov_count), 32'd0);

    // Gapped input, same word (the in-task check confirms no early push)
    send_word(24'hA5C3F0, 1'b1, 1'b0, 1'b0);
    chk("gap_dout",  32'(bus.ov_dout), 32'hA5C3F0);
    chk("gap_count", 32'(bus.ov_count), 32'd1);
    pop_one();

    // Fill and overflow
    for (int k = 1; k <= 8; k++) send_word(DW'(k), 1'b0, 1'b0, 1'b0);
    chk("fill_full",  32'(bus.o_full), 32'd1);
    chk("fill_count", 32'(bus.ov_count), 32'd8);
    chk("fill_ovf0",  32'(bus.o_overflow), 32'd0);
    send_word(24'h000009, 1'b0, 1'b0, 1'b0);
    chk("ovf_set",   32'(bus.o_overflow), 32'd1);
    chk("ovf_count", 32'(bus.ov_count), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), 32'(bus.ov_dout), 32'(k));
      pop_one();
    end
    chk("drain_empty_valid", 32'(bus.o_dout_valid), 32'd0);
    chk("drain_empty_dout",  32'(bus.ov_dout), 32'd0);
    chk("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    bus.i_clr_overflow = 1'b1; tick(); bus.i_clr_overflow = 1'b0;
    chk("ovf_clr", 32'(bus.o_overflow), 32'd0);

    // Clear on the same edge as a drop: set wins
    for (int k = 1; k <= 8; k++) send_word(DW'(k), 1'b0, 1'b0, 1'b0);
    send_word(24'h0000AA, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", 32'(bus.o_overflow), 32'd1);
    bus.i_clr_overflow = 1'b1; tick(); bus.i_clr_overflow = 1'b0;
    chk("clr_next", 32'(bus.o_overflow), 32'd0);
    for (int k = 1; k <= 8; k++) pop_one();
    chk("clr_drained", 32'(bus.ov_count), 32'd0);

    // Full with simultaneous pop: push accepted, no overflow
    for (int k = 1; k <= 8; k++) send_word(DW'(k), 1'b0, 1'b0, 1'b0);
    send_word(24'h000009, 1'b0, 1'b1, 1'b0);
    chk("fullpop_ovf",   32'(bus.o_overflow), 32'd0);
    chk("fullpop_count", 32'(bus.ov_count), 32'd8);
    chk("fullpop_full",  32'(bus.o_full), 32'd1);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fullpop_drain_%0d", k), 32'(bus.ov_dout), 32'(k));
      pop_one();
    end
    chk("fullpop_empty", 32'(bus.ov_count), 32'd0);

    // Reset mid-word plus stored word discarded
    send_word(24'h00BEEF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.i_en = 1'b1; bus.i_din_valid = 1'b1; bus.i_din = 1'(i % 2); tick();
    end
    bus.i_din_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    tick();
    i_rst_n = 1'b1;
    tick();
    send_word(24'h123456, 1'b0, 1'b0, 1'b0);
    chk("midrst_dout",  32'(bus.ov_dout), 32'h123456);
    chk("midrst_count", 32'(bus.ov_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_rx_buffer.md
SERIAL_RX_BUFFER -- requirements
Module: serial_rx_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 24, width of one assembled word in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, number of word entries; SHALL be a power of two, 2 or more.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_en  in  1  enable for bit capture; pop side is independent of i_en.
REQ-006 i_din  in  1  serial data bit.
REQ-007 i_din_valid  in  1  i_din valid this cycle.
REQ-008 ov_dout  out  DATA_WIDTH  head-of-FIFO word; show-ahead.
REQ-009 o_dout_valid  out  1  FIFO non-empty; ov_dout valid.
REQ-010 i_dout_ready  in  1  consumer accepts ov_dout this cycle.
REQ-011 o_full  out  1  count equals FIFO_DEPTH.
REQ-012 ov_count  out  clog2(FIFO_DEPTH)+1  words currently stored.
REQ-013 o_overflow  out  1  sticky flag, set when a completed word is dropped.
REQ-014 i_clr_overflow  in  1  synchronous clear of o_overflow.

Function
REQ-015 Capture: a bit SHALL be accepted only on a cycle with i_en=1 and i_din_valid=1; the block SHALL shift it into a DATA_WIDTH shift register MSB-first.
REQ-016 Bit counter: 0..DATA_WIDTH-1; it SHALL increment per accepted bit and wrap to 0 on the DATA_WIDTH-th bit.
REQ-017 Idle cycles (i_en=0 or i_din_valid=0) SHALL hold the shift register and bit counter unchanged, with no timeout.
REQ-018 Word complete: on the cycle the DATA_WIDTH-th bit is accepted, the assembled word (previous DATA_WIDTH-1 bits plus current bit as LSB) SHALL be the push candidate that same edge.
REQ-019 Latency: a pushed word into an empty FIFO SHALL appear on ov_dout with o_dout_valid=1 on the cycle after the edge of its last bit.
REQ-020 Pop SHALL occur on an edge where o_dout_valid=1 and i_dout_ready=1; the read pointer advances and the next word (if any) SHALL be presented the following cycle.
REQ-021 i_dout_ready while empty SHALL have no effect.
REQ-022 Push when count<FIFO_DEPTH: the word SHALL be written at the write pointer and the pointer incremented modulo FIFO_DEPTH.
REQ-023 Push when full with a simultaneous pop: both SHALL occur, and count SHALL stay at FIFO_DEPTH.
REQ-024 Push when full without a pop: the word SHALL be dropped, FIFO contents unchanged, and o_overflow set to 1 on that edge.
REQ-025 Simultaneous push and pop when not full: count SHALL be unchanged.
REQ-026 When empty and pushed, count SHALL go 0->1 with no bypass; the word SHALL be visible next cycle per REQ-019.
REQ-027 o_overflow SHALL clear on an edge with i_clr_overflow=1, except when a drop occurs on the same edge; set SHALL win.
REQ-028 When o_dout_valid=0, ov_dout SHALL be driven to all zeros.
REQ-029 o_full and o_dout_valid SHALL be decoded from ov_count (count==FIFO_DEPTH and count!=0 respectively), with no extra cycle of lag.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; ov_count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-031 i_rst_n=0 SHALL asynchronously clear the bit counter, shift register, both pointers, ov_count and o_overflow.
REQ-032 During and after reset, ov_dout=0, o_dout_valid=0, o_full=0, ov_count=0 and o_overflow=0.
REQ-033 Reset mid-word SHALL discard the partial bits; capture SHALL restart at bit position 0 after deassertion.
REQ-034 Reset SHALL discard all stored FIFO words; memory contents need not be cleared, since they are unobservable while empty.

Verification
REQ-035 Single word: 24 bits of 0xA5C3F0 MSB-first, i_dout_ready=0 -> next cycle ov_dout=0xA5C3F0, o_dout_valid=1, ov_count=1.
REQ-036 Gapped input: same word with i_din_valid toggling every other cycle and i_en low for 5 cycles mid-word -> identical result to REQ-035, with no spurious push.
REQ-037 Fill and overflow: 9 words 0x000001..0x000009, i_dout_ready=0 -> o_full=1, ov_count=8, o_overflow=1; draining yields 0x000001..0x000008 in order, with 0x000009 lost.
REQ-038 Full with simultaneous pop: FIFO full, 9th word completes on a cycle with i_dout_ready=1 -> o_overflow stays 0, ov_count=8, 0x000001 popped, 0x000009 last in order.
REQ-039 Overflow clear priority: i_clr_overflow=1 on the same edge as a drop -> o_overflow=1; i_clr_overflow=1 next cycle with no drop -> o_overflow=0.
REQ-040 Reset mid-word: 10 bits sent, i_rst_n pulsed low, then a full word 0x123456 -> ov_dout=0x123456 and ov_count=1.
